// File: rtl/multi_alarm_clock_core.sv
// 24-hour BCD timekeeping core with internal 1 Hz divider, N alarm slots and a
// ring / snooze / auto-timeout state machine.
module multi_alarm_clock_core #(
    parameter int CLK_HZ     = 125000000,
    parameter int N_ALARM    = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    localparam int IDX_W     = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_set_en,
    input  logic [5:0]       i_set_hh,
    input  logic [6:0]       i_set_mm,
    input  logic [6:0]       i_set_ss,
    input  logic             i_alm_we,
    input  logic [IDX_W-1:0] i_alm_idx,
    input  logic [5:0]       i_alm_hh,
    input  logic [6:0]       i_alm_mm,
    input  logic             i_alm_ena,
    input  logic             i_stop,
    input  logic             i_snooze,
    output logic [5:0]       o_time_hh,
    output logic [6:0]       o_time_mm,
    output logic [6:0]       o_time_ss,
    output logic             o_sec_pulse,
    output logic             o_blink,
    output logic             o_ringing,
    output logic             o_snoozing,
    output logic [IDX_W-1:0] o_ring_idx
);

    localparam int DIV_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RC_W    = 8;
    localparam int SNZ_LEN = SNOOZE_MIN * 60;
    localparam int SC_W    = $clog2(SNZ_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RING,
        ST_SNZ
    } state_t;

    function automatic logic f_ms_ok(input logic [6:0] v);
        return (v[3:0] <= 4'd9) && (v[6:4] <= 3'd5);
    endfunction

    function automatic logic f_hh_ok(input logic [5:0] v);
        return (v[3:0] <= 4'd9) &&
               ((v[5:4] < 2'd2) || ((v[5:4] == 2'd2) && (v[3:0] <= 4'd3)));
    endfunction

    logic [DIV_W-1:0] r_div;
    logic [5:0]       r_hh;
    logic [6:0]       r_mm;
    logic [6:0]       r_ss;
    logic             r_sec_pulse;
    logic [5:0]       r_alm_hh [N_ALARM];
    logic [6:0]       r_alm_mm [N_ALARM];
    logic             r_alm_en [N_ALARM];

    state_t           r_state;
    state_t           w_state_nx;
    logic [RC_W-1:0]  r_ring_cnt;
    logic [RC_W-1:0]  w_ring_cnt_nx;
    logic [SC_W-1:0]  r_snz_cnt;
    logic [SC_W-1:0]  w_snz_cnt_nx;
    logic [IDX_W-1:0] r_ring_idx;
    logic [IDX_W-1:0] w_ring_idx_nx;

    logic             w_tc;
    logic             w_set_ok;
    logic             w_alm_ok;
    logic [5:0]       w_nx_hh;
    logic [6:0]       w_nx_mm;
    logic [6:0]       w_nx_ss;
    logic             w_match;
    logic [IDX_W-1:0] w_match_idx;

    assign w_tc     = (r_div == DIV_W'(CLK_HZ - 1));
    assign w_set_ok = i_set_en && f_hh_ok(i_set_hh) && f_ms_ok(i_set_mm) && f_ms_ok(i_set_ss);
    assign w_alm_ok = i_alm_we && f_hh_ok(i_alm_hh) && f_ms_ok(i_alm_mm) &&
                      (int'(i_alm_idx) < N_ALARM);

    // One-second increment with digit-by-digit BCD carry.
    always_comb begin
        w_nx_hh = r_hh;
        w_nx_mm = r_mm;
        w_nx_ss = r_ss;
        if (r_ss[3:0] != 4'd9) begin
            w_nx_ss[3:0] = r_ss[3:0] + 4'd1;
        end else if (r_ss[6:4] != 3'd5) begin
            w_nx_ss = {r_ss[6:4] + 3'd1, 4'd0};
        end else begin
            w_nx_ss = 7'd0;
            if (r_mm[3:0] != 4'd9) begin
                w_nx_mm[3:0] = r_mm[3:0] + 4'd1;
            end else if (r_mm[6:4] != 3'd5) begin
                w_nx_mm = {r_mm[6:4] + 3'd1, 4'd0};
            end else begin
                w_nx_mm = 7'd0;
                if (r_hh == 6'h23) begin
                    w_nx_hh = 6'd0;
                end else if (r_hh[3:0] == 4'd9) begin
                    w_nx_hh = {r_hh[5:4] + 2'd1, 4'd0};
                end else begin
                    w_nx_hh[3:0] = r_hh[3:0] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div       <= '0;
            r_hh        <= '0;
            r_mm        <= '0;
            r_ss        <= '0;
            r_sec_pulse <= 1'b0;
        end else begin
            r_sec_pulse <= 1'b0;
            if (w_set_ok) begin
                r_hh  <= i_set_hh;
                r_mm  <= i_set_mm;
                r_ss  <= i_set_ss;
                r_div <= '0;
            end else if (w_tc) begin
                r_hh        <= w_nx_hh;
                r_mm        <= w_nx_mm;
                r_ss        <= w_nx_ss;
                r_div       <= '0;
                r_sec_pulse <= 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < N_ALARM; k++) begin
                r_alm_hh[k] <= '0;
                r_alm_mm[k] <= '0;
                r_alm_en[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < N_ALARM; k++) begin
                if (w_alm_ok && (int'(i_alm_idx) == k)) begin
                    r_alm_hh[k] <= i_alm_hh;
                    r_alm_mm[k] <= i_alm_mm;
                    r_alm_en[k] <= i_alm_ena;
                end
            end
        end
    end

    // Matches only on the freshly advanced time, so a SET load can never ring.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int k = N_ALARM - 1; k >= 0; k--) begin
            if (r_alm_en[k] && (r_alm_hh[k] == r_hh) && (r_alm_mm[k] == r_mm)) begin
                w_match     = 1'b1;
                w_match_idx = IDX_W'(k);
            end
        end
        w_match = w_match && r_sec_pulse && (r_ss == 7'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_ring_idx <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_ring_cnt <= w_ring_cnt_nx;
            r_snz_cnt  <= w_snz_cnt_nx;
            r_ring_idx <= w_ring_idx_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_ring_cnt_nx = r_ring_cnt;
        w_snz_cnt_nx  = r_snz_cnt;
        w_ring_idx_nx = r_ring_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_match) begin
                    w_state_nx    = ST_RING;
                    w_ring_cnt_nx = RC_W'(RING_SEC);
                    w_ring_idx_nx = w_match_idx;
                end
            end
            ST_RING: begin
                if (i_stop) begin
                    w_state_nx    = ST_IDLE;
                    w_ring_cnt_nx = '0;
                end else if (i_snooze) begin
                    w_state_nx    = ST_SNZ;
                    w_ring_cnt_nx = '0;
                    w_snz_cnt_nx  = SC_W'(SNZ_LEN);
                end else if (r_sec_pulse) begin
                    if (r_ring_cnt <= RC_W'(1)) begin
                        w_state_nx    = ST_IDLE;
                        w_ring_cnt_nx = '0;
                    end else begin
                        w_ring_cnt_nx = r_ring_cnt - RC_W'(1);
                    end
                end
            end
            ST_SNZ: begin
                if (i_stop) begin
                    w_state_nx   = ST_IDLE;
                    w_snz_cnt_nx = '0;
                end else if (r_sec_pulse) begin
                    if (r_snz_cnt <= SC_W'(1)) begin
                        w_state_nx    = ST_RING;
                        w_snz_cnt_nx  = '0;
                        w_ring_cnt_nx = RC_W'(RING_SEC);
                    end else begin
                        w_snz_cnt_nx = r_snz_cnt - SC_W'(1);
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign o_time_hh   = r_hh;
    assign o_time_mm   = r_mm;
    assign o_time_ss   = r_ss;
    assign o_sec_pulse = r_sec_pulse;
    assign o_blink     = (r_div < DIV_W'(CLK_HZ / 2));
    assign o_ringing   = (r_state == ST_RING);
    assign o_snoozing  = (r_state == ST_SNZ);
    assign o_ring_idx  = r_ring_idx;

endmodule

// File: tb/tb_multi_alarm_clock_core.sv
// Scenario bench for multi_alarm_clock_core: time wrap, set validation, alarm
// priority, timeout, snooze and reset recovery, with a queue of expected times.
module tb_multi_alarm_clock_core;

    localparam int IDX_W = 2;

    logic             clk;
    logic             reset;
    logic             set_en;
    logic [5:0]       set_hh;
    logic [6:0]       set_mm;
    logic [6:0]       set_ss;
    logic             alm_we;
    logic [IDX_W-1:0] alm_idx;
    logic [5:0]       alm_hh;
    logic [6:0]       alm_mm;
    logic             alm_ena;
    logic             stop;
    logic             snooze;
    logic [5:0]       time_hh;
    logic [6:0]       time_mm;
    logic [6:0]       time_ss;
    logic             sec_pulse;
    logic             blink;
    logic             ringing;
    logic             snoozing;
    logic [IDX_W-1:0] ring_idx;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [19:0] exp_q[$];

    multi_alarm_clock_core #(
        .CLK_HZ    (4),
        .N_ALARM   (4),
        .SNOOZE_MIN(1),
        .RING_SEC  (3)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_set_en   (set_en),
        .i_set_hh   (set_hh),
        .i_set_mm   (set_mm),
        .i_set_ss   (set_ss),
        .i_alm_we   (alm_we),
        .i_alm_idx  (alm_idx),
        .i_alm_hh   (alm_hh),
        .i_alm_mm   (alm_mm),
        .i_alm_ena  (alm_ena),
        .i_stop     (stop),
        .i_snooze   (snooze),
        .o_time_hh  (time_hh),
        .o_time_mm  (time_mm),
        .o_time_ss  (time_ss),
        .o_sec_pulse(sec_pulse),
        .o_blink    (blink),
        .o_ringing  (ringing),
        .o_snoozing (snoozing),
        .o_ring_idx (ring_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] cur_time();
        return {time_hh, time_mm, time_ss};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic set_time(input logic [5:0] hh, input logic [6:0] mm, input logic [6:0] ss);
        set_en = 1'b1;
        set_hh = hh;
        set_mm = mm;
        set_ss = ss;
        tick(1);
        set_en = 1'b0;
    endtask

    task automatic write_alarm(input logic [IDX_W-1:0] idx, input logic [5:0] hh,
                               input logic [6:0] mm, input logic ena);
        alm_we  = 1'b1;
        alm_idx = idx;
        alm_hh  = hh;
        alm_mm  = mm;
        alm_ena = ena;
        tick(1);
        alm_we  = 1'b0;
    endtask

    task automatic press(input logic s_stop, input logic s_snooze);
        stop   = s_stop;
        snooze = s_snooze;
        tick(1);
        stop   = 1'b0;
        snooze = 1'b0;
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 8 && !ok; c++) begin
            tick(1);
            if (sec_pulse) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tests_run++;
        if ({cur_time(), sec_pulse, blink, ringing, snoozing, ring_idx} !== {20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got %h, expected %h",
                     {cur_time(), sec_pulse, blink, ringing, snoozing, ring_idx},
                     {20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
        end
    endtask

    task automatic test_wrap();
        logic [19:0] e;
        logic        exp_blink;
        logic        exp_pulse;
        set_time(6'h23, 7'h59, 7'h58);
        exp_q.push_back({6'h23, 7'h59, 7'h59});
        exp_q.push_back({6'h00, 7'h00, 7'h00});
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) tick(1);
            exp_blink = ((i % 4) < 2);
            exp_pulse = (i > 0) && ((i % 4) == 0);
            tests_run++;
            if (blink !== exp_blink) begin
                tests_failed++;
                $display("[TB] FAIL wrap_blink cycle %0d: got %b, expected %b", i, blink, exp_blink);
            end
            tests_run++;
            if (sec_pulse !== exp_pulse) begin
                tests_failed++;
                $display("[TB] FAIL wrap_pulse cycle %0d: got %b, expected %b", i, sec_pulse, exp_pulse);
            end
            if (sec_pulse) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_extra_pulse: got time %h, expected no pulse", cur_time());
                end else begin
                    e = exp_q.pop_front();
                    if (cur_time() !== e) begin
                        tests_failed++;
                        $display("[TB] FAIL wrap_time: got %h, expected %h", cur_time(), e);
                    end
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_missing_pulse: got %0d left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_invalid_set();
        logic [19:0] e;
        tick(1);
        set_time(6'h24, 7'h12, 7'h34);
        tests_run++;
        if (cur_time() !== 20'h0) begin
            tests_failed++;
            $display("[TB] FAIL bad_hour_set: got %h, expected %h", cur_time(), 20'h0);
        end
        set_time(6'h12, 7'h34, 7'h5A);
        tests_run++;
        if (cur_time() !== 20'h0) begin
            tests_failed++;
            $display("[TB] FAIL bad_sec_set: got %h, expected %h", cur_time(), 20'h0);
        end
        tick(1);
        tests_run++;
        if ({sec_pulse, cur_time()} !== {1'b1, 6'h00, 7'h00, 7'h01}) begin
            tests_failed++;
            $display("[TB] FAIL bad_set_divider: got %h, expected %h",
                     {sec_pulse, cur_time()}, {1'b1, 6'h00, 7'h00, 7'h01});
        end
        set_time(6'h12, 7'h34, 7'h56);
        exp_q.push_back({6'h12, 7'h34, 7'h57});
        tests_run++;
        if ({cur_time(), blink, sec_pulse} !== {6'h12, 7'h34, 7'h56, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL good_set_load: got %h, expected %h",
                     {cur_time(), blink, sec_pulse}, {6'h12, 7'h34, 7'h56, 1'b1, 1'b0});
        end
        tick(3);
        tests_run++;
        if (sec_pulse !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL good_set_early_pulse: got %b, expected 0", sec_pulse);
        end
        tick(1);
        e = exp_q.pop_front();
        tests_run++;
        if ({sec_pulse, cur_time()} !== {1'b1, e}) begin
            tests_failed++;
            $display("[TB] FAIL good_set_advance: got %h, expected %h", {sec_pulse, cur_time()}, {1'b1, e});
        end
    endtask

    task automatic test_alarm_timeout();
        bit ok;
        logic [19:0] e;
        apply_reset();
        write_alarm(2'd2, 6'h07, 7'h00, 1'b1);
        set_time(6'h06, 7'h59, 7'h59);
        exp_q.push_back({6'h07, 7'h00, 7'h00});
        wait_pulse(ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || cur_time() !== e || ringing !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL alarm_time: got ok=%b time=%h ring=%b, expected ok=1 time=%h ring=0",
                     ok, cur_time(), ringing, e);
        end
        tick(1);
        tests_run++;
        if ({ringing, snoozing, ring_idx} !== {1'b1, 1'b0, 2'd2}) begin
            tests_failed++;
            $display("[TB] FAIL alarm_ring: got %b, expected %b", {ringing, snoozing, ring_idx}, {1'b1, 1'b0, 2'd2});
        end
        for (int k = 1; k <= 3; k++) begin
            wait_pulse(ok);
            tick(1);
            tests_run++;
            if (!ok || ringing !== (k < 3)) begin
                tests_failed++;
                $display("[TB] FAIL ring_timeout pulse %0d: got ok=%b ring=%b, expected ok=1 ring=%b",
                         k, ok, ringing, (k < 3));
            end
        end
    endtask

    task automatic test_priority();
        bit ok;
        apply_reset();
        write_alarm(2'd3, 6'h07, 7'h00, 1'b1);
        write_alarm(2'd1, 6'h07, 7'h00, 1'b1);
        set_time(6'h06, 7'h59, 7'h59);
        wait_pulse(ok);
        tick(1);
        tests_run++;
        if (!ok || {ringing, ring_idx} !== {1'b1, 2'd1}) begin
            tests_failed++;
            $display("[TB] FAIL priority_idx: got ok=%b %b, expected ok=1 %b", ok, {ringing, ring_idx}, {1'b1, 2'd1});
        end
        press(1'b1, 1'b1);
        tests_run++;
        if ({ringing, snoozing} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL stop_beats_snooze: got %b, expected 00", {ringing, snoozing});
        end
    endtask

    task automatic test_snooze();
        bit ok;
        bit all_ok;
        apply_reset();
        write_alarm(2'd3, 6'h07, 7'h00, 1'b1);
        set_time(6'h06, 7'h59, 7'h59);
        wait_pulse(ok);
        tick(1);
        press(1'b0, 1'b1);
        tests_run++;
        if (!ok || {ringing, snoozing} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL snooze_enter: got ok=%b %b, expected ok=1 01", ok, {ringing, snoozing});
        end
        all_ok = 1'b1;
        for (int k = 1; k <= 59; k++) begin
            wait_pulse(ok);
            all_ok = all_ok && ok;
        end
        tick(1);
        tests_run++;
        if (!all_ok || {ringing, snoozing} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL snooze_hold_59: got ok=%b %b, expected ok=1 01", all_ok, {ringing, snoozing});
        end
        wait_pulse(ok);
        tick(1);
        tests_run++;
        if (!ok || {ringing, snoozing, ring_idx} !== {1'b1, 1'b0, 2'd3}) begin
            tests_failed++;
            $display("[TB] FAIL snooze_rering: got ok=%b %b, expected ok=1 %b",
                     ok, {ringing, snoozing, ring_idx}, {1'b1, 1'b0, 2'd3});
        end
        press(1'b1, 1'b0);
        tests_run++;
        if ({ringing, snoozing} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL snooze_stop: got %b, expected 00", {ringing, snoozing});
        end
    endtask

    task automatic test_no_false_trigger();
        bit ok;
        apply_reset();
        write_alarm(2'd0, 6'h07, 7'h00, 1'b1);
        write_alarm(2'd1, 6'h06, 7'h5A, 1'b1);
        set_time(6'h07, 7'h00, 7'h00);
        tick(2);
        tests_run++;
        if (ringing !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL set_no_trigger: got %b, expected 0", ringing);
        end
        set_time(6'h06, 7'h59, 7'h59);
        wait_pulse(ok);
        tick(1);
        tests_run++;
        if (!ok || {ringing, ring_idx} !== {1'b1, 2'd0}) begin
            tests_failed++;
            $display("[TB] FAIL invalid_write_ignored: got ok=%b %b, expected ok=1 %b", ok, {ringing, ring_idx}, {1'b1, 2'd0});
        end
    endtask

    task automatic test_reset_in_snooze();
        bit ok;
        apply_reset();
        write_alarm(2'd2, 6'h07, 7'h00, 1'b1);
        set_time(6'h06, 7'h59, 7'h59);
        wait_pulse(ok);
        tick(1);
        press(1'b0, 1'b1);
        tests_run++;
        if (!ok || snoozing !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_setup_snz: got ok=%b snz=%b, expected ok=1 snz=1", ok, snoozing);
        end
        apply_reset();
        tests_run++;
        if ({cur_time(), sec_pulse, blink, ringing, snoozing, ring_idx} !== {20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_snooze: got %h, expected %h",
                     {cur_time(), sec_pulse, blink, ringing, snoozing, ring_idx},
                     {20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
        end
        set_time(6'h06, 7'h59, 7'h59);
        wait_pulse(ok);
        tick(1);
        tests_run++;
        if (!ok || ringing !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL slots_cleared_by_reset: got ok=%b ring=%b, expected ok=1 ring=0", ok, ringing);
        end
    endtask

    initial begin
        reset   = 1'b1;
        set_en  = 1'b0;
        set_hh  = '0;
        set_mm  = '0;
        set_ss  = '0;
        alm_we  = 1'b0;
        alm_idx = '0;
        alm_hh  = '0;
        alm_mm  = '0;
        alm_ena = 1'b0;
        stop    = 1'b0;
        snooze  = 1'b0;
        test_reset();
        test_wrap();
        test_invalid_set();
        test_alarm_timeout();
        test_priority();
        test_snooze();
        test_no_false_trigger();
        test_reset_in_snooze();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
